// File: rtl/subt_seq.sv
// Multi-nibble subtraction sequencer: drives one external 4-bit ripple subtractor
// LSB-first and accumulates a W-bit difference. Optional macro: SUBT_SEQ_SIGNED_EN.
module subt_seq #(
  localparam int unsigned NIB = 4,
  localparam int unsigned W   = 4 * NIB
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic [3:0]   sub_a,
  output logic [3:0]   sub_b,
  output logic         sub_bin,
  input  logic [3:0]   sub_d,
  input  logic         sub_bout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         bout,
  output logic         ovf
);

  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_idx;
  logic            r_borrow;
  logic [W-1:0]    r_opa;
  logic [W-1:0]    r_opb;
  logic [W-1:0]    r_result;
  logic            r_bout;
  logic            r_done;
  logic            w_last;

  assign w_last = (r_idx == IDXW'(NIB - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Nibble select toward the subtractor; everything idles at zero outside RUN.
  always_comb begin
    sub_a   = '0;
    sub_b   = '0;
    sub_bin = 1'b0;
    if (r_state == ST_RUN) begin
      sub_bin = r_borrow;
      for (int unsigned i = 0; i < NIB; i++) begin
        if (r_idx == IDXW'(i)) begin
          sub_a = r_opa[4*i +: 4];
          sub_b = r_opb[4*i +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_opa    <= opa;
            r_opb    <= opb;
            r_idx    <= '0;
            r_borrow <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (r_idx == IDXW'(i)) r_result[4*i +: 4] <= sub_d;
          end
          r_borrow <= sub_bout;
          if (w_last) begin
            r_idx  <= '0;
            r_bout <= sub_bout;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // done is registered off the DONE state, so the pulse lands NIB+1 edges after
  // the accepting edge while the FSM is already back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_done <= 1'b0;
    else     r_done <= (r_state == ST_DONE);
  end

`ifdef SUBT_SEQ_SIGNED_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= (r_opa[W-1] != r_opb[W-1]) && (sub_d[3] != r_opa[W-1]);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (r_state == ST_RUN);
  assign done   = r_done;
  assign result = r_result;
  assign bout   = r_bout;

endmodule

// File: tb/tb_subt_seq.sv
// Scoreboard bench for subt_seq with a behavioural 4-bit ripple subtractor attached.
module tb_subt_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [3:0]  sub_a;
  logic [3:0]  sub_b;
  logic        sub_bin;
  logic [3:0]  sub_d;
  logic        sub_bout;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        bout;
  logic        ovf;

  logic [4:0]  w_diff;

  subt_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opa      (opa),
    .opb      (opb),
    .sub_a    (sub_a),
    .sub_b    (sub_b),
    .sub_bin  (sub_bin),
    .sub_d    (sub_d),
    .sub_bout (sub_bout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .bout     (bout),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  assign w_diff   = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0, sub_bin};
  assign sub_d    = w_diff[3:0];
  assign sub_bout = w_diff[4];

  typedef struct {
    logic [15:0] res;
    logic        bo;
    logic        ov;
    int          cyc;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ntag   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic f_ovf(input logic [15:0] a, input logic [15:0] b);
`ifdef SUBT_SEQ_SIGNED_EN
    logic [15:0] r;
    r = a - b;
    return (a[15] != b[15]) && (r[15] != a[15]);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("op%0d_result", e.tag), {16'b0, result}, {16'b0, e.res});
        chk($sformatf("op%0d_bout", e.tag), {31'b0, bout}, {31'b0, e.bo});
        chk($sformatf("op%0d_ovf", e.tag), {31'b0, ovf}, {31'b0, e.ov});
        chk($sformatf("op%0d_latency", e.tag), cyc, e.cyc);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns one negedge later with start low.
  task automatic launch(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic bo, input logic ov);
    exp_t e;
    opa   = a;
    opb   = b;
    start = 1'b1;
    e.res = res;
    e.bo  = bo;
    e.ov  = ov;
    e.cyc = cyc + 6;
    e.tag = ntag;
    ntag++;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20; k++) begin
      if (done) break;
      @(negedge clk);
    end
    if (k == 20) chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic bo, input logic ov);
    launch(a, b, res, bo, ov);
    wait_done();
  endtask

  logic [3:0] exp_na  [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] exp_nb  [4] = '{4'h5, 4'h3, 4'h2, 4'h0};
  logic       exp_bin [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [15:0] ra;
    logic [15:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    opa   = '0;
    opb   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_bout",   {31'b0, bout}, 32'd0);
    chk("rst_ovf",    {31'b0, ovf}, 32'd0);
    chk("rst_sub",    {23'b0, sub_a, sub_b, sub_bin}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic op with per-nibble observation of the subtractor interface.
    launch(16'h1234, 16'h0235, 16'h0FFF, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_busy%0d", k), {31'b0, busy}, 32'd1);
      chk($sformatf("t2_sub_a%0d", k), {28'b0, sub_a}, {28'b0, exp_na[k]});
      chk($sformatf("t2_sub_b%0d", k), {28'b0, sub_b}, {28'b0, exp_nb[k]});
      chk($sformatf("t2_sub_bin%0d", k), {31'b0, sub_bin}, {31'b0, exp_bin[k]});
      @(negedge clk);
    end
    chk("t2_busy_after", {31'b0, busy}, 32'd0);
    chk("t2_sub_idle", {23'b0, sub_a, sub_b, sub_bin}, 32'd0);
    wait_done();

    // Reset in the middle of RUN aborts with no done.
    opa   = 16'h5555;
    opb   = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_busy",   {31'b0, busy}, 32'd0);
      chk("t1_done",   {31'b0, done}, 32'd0);
      chk("t1_result", {16'b0, result}, 32'd0);
      chk("t1_flags",  {30'b0, bout, ovf}, 32'd0);
      chk("t1_sub",    {23'b0, sub_a, sub_b, sub_bin}, 32'd0);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t1_idle_busy", {31'b0, busy}, 32'd0);

    // Directed vectors including borrow and signed-overflow boundaries.
    do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
`ifdef SUBT_SEQ_SIGNED_EN
    do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);
`else
    do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
`endif
    do_op(16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
    do_op(16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);

    // start held high: one accept per 6 cycles, operands latched only at accept.
    launch(16'h9000, 16'h1000, 16'h8000, 1'b0, 1'b0);
    start = 1'b1;
    opa   = 16'h0400;
    opb   = 16'h0500;
    q.push_back('{res: 16'hFF00, bo: 1'b1, ov: 1'b0, cyc: cyc + 11, tag: ntag});
    ntag++;
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("t4_busy_op1", busy_cnt, 32'd4);
    busy_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (busy) busy_cnt++;
      if (k == 1) begin
        start = 1'b0;
        opa   = 16'h1111;
        opb   = 16'h2222;
      end
      @(negedge clk);
    end
    chk("t4_busy_op2", busy_cnt, 32'd4);
    repeat (10) @(negedge clk);
    chk("t4_idle_busy", {31'b0, busy}, 32'd0);

    // Random operands against a golden difference.
    for (int n = 0; n < 500; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, ra - rb, (ra < rb), f_ovf(ra, rb));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
